// File: rtl/aes_round_ctrl_pkg.sv
// Shared constants for the AES-128 round sequencer: FSM encodings, round count
// and Rcon seed/reduction polynomial.
package aes_round_ctrl_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INIT  = 2'd1;
  localparam logic [1:0] S_ROUND = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int         AES_NR    = 10;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam logic [7:0] RCON_POLY = 8'h1B;

endpackage

// File: rtl/aes_rcon_gen.sv
// Rcon register for the key schedule: reloads to 01 on load, steps by
// xtime (multiply by x in GF(2^8)) on advance.
module aes_rcon_gen
  import aes_round_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] rcon
);

  localparam logic [W-1:0] INIT = W'(RCON_INIT);
  localparam logic [W-1:0] POLY = W'(RCON_POLY);

  logic [W-1:0] r_rcon;
  logic [W-1:0] w_xtime;

  assign w_xtime = {r_rcon[W-2:0], 1'b0} ^ (r_rcon[W-1] ? POLY : '0);

  // NOTE: sequential state is updated with <= so every register samples the
  // pre-edge values of its neighbours, regardless of block ordering.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_rcon <= INIT;
    end else if (load) begin
      r_rcon <= INIT;
    end else if (advance) begin
      r_rcon <= w_xtime;
    end
  end

  assign rcon = r_rcon;

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 datapath: start handshake, load, NR rounds,
// result hold. Optional 1-deep start queue enabled by defining AES_CMD_QUEUE_EN.
module aes_round_ctrl
  import aes_round_ctrl_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int ROUND_W = 4,
  parameter int RCON_W  = 8
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic               start,
  output logic               start_ack,
  output logic               ready,
  output logic               load_state,
  output logic               load_key,
  output logic               round_en,
  output logic [ROUND_W-1:0] round,
  output logic [RCON_W-1:0]  rcon,
  output logic               last_round,
  output logic               cipher_valid,
  input  logic               out_ack,
  output logic               busy_err
);

  localparam logic [ROUND_W-1:0] ROUND_LAST = ROUND_W'(NR);

  logic [1:0]         r_state;
  logic [1:0]         w_state_next;
  logic [ROUND_W-1:0] r_round;
  logic               r_busy_err;
  logic               w_last;
  logic               w_start_busy;
  logic               w_ack_done;
  logic               w_take_pending;
  logic               w_busy_err_next;

  assign w_last       = (r_state == S_ROUND) && (r_round == ROUND_LAST);
  assign w_start_busy = start && (r_state != S_IDLE);
  assign w_ack_done   = out_ack && (r_state == S_DONE);

`ifdef AES_CMD_QUEUE_EN
  logic r_pending;
  logic w_queue;

  // A start arriving together with out_ack in S_DONE is dropped, not queued.
  assign w_queue         = w_start_busy && !r_pending && !w_ack_done;
  assign w_take_pending  = w_ack_done && r_pending;
  assign w_busy_err_next = w_start_busy && !w_queue;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_pending <= 1'b0;
    end else if (w_take_pending) begin
      r_pending <= 1'b0;
    end else if (w_queue) begin
      r_pending <= 1'b1;
    end
  end
`else
  assign w_take_pending  = 1'b0;
  assign w_busy_err_next = w_start_busy;
`endif

  // NOTE: the default assignment first keeps this block purely combinational;
  // a path that leaves w_state_next unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)      w_state_next = S_INIT;
      S_INIT:                  w_state_next = S_ROUND;
      S_ROUND: if (w_last)     w_state_next = S_DONE;
      S_DONE:  if (w_ack_done) w_state_next = w_take_pending ? S_INIT : S_IDLE;
      default:                 w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= S_IDLE;
      r_round    <= '0;
      r_busy_err <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_busy_err <= w_busy_err_next;
      if (r_state == S_INIT) begin
        r_round <= ROUND_W'(1);
      end else if (r_state == S_ROUND) begin
        r_round <= w_last ? '0 : r_round + ROUND_W'(1);
      end
    end
  end

  // Rcon holds its final value after the last round; it is reseeded in S_INIT.
  aes_rcon_gen #(
    .W (RCON_W)
  ) u_rcon_gen (
    .clk     (clk),
    .rst_    (rst_),
    .load    (r_state == S_INIT),
    .advance ((r_state == S_ROUND) && !w_last),
    .rcon    (rcon)
  );

  assign ready        = (r_state == S_IDLE);
  assign start_ack    = (r_state == S_INIT);
  assign load_state   = (r_state == S_INIT);
  assign load_key     = (r_state == S_INIT);
  assign round_en     = (r_state == S_ROUND);
  assign round        = r_round;
  assign last_round   = w_last;
  assign cipher_valid = (r_state == S_DONE);
  assign busy_err     = r_busy_err;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: cycle table for a full run plus
// hand-written corner sequences; a scoreboard checks round/rcon per round cycle.
module tb_aes_round_ctrl;

  typedef struct packed {
    logic       ready;
    logic       start_ack;
    logic       load_state;
    logic       load_key;
    logic       round_en;
    logic [3:0] round;
    logic       last;
    logic       valid;
    logic       busy_err;
  } out_t;

  typedef struct {
    logic start;
    logic out_ack;
    out_t exp;
  } vec_t;

  typedef struct packed {
    logic [3:0] round;
    logic [7:0] rcon;
    logic       last;
  } sb_t;

  localparam int NVEC = 34;

  logic       clk;
  logic       rst_;
  logic       start;
  logic       out_ack;
  logic       start_ack;
  logic       ready;
  logic       load_state;
  logic       load_key;
  logic       round_en;
  logic [3:0] round;
  logic [7:0] rcon;
  logic       last_round;
  logic       cipher_valid;
  logic       busy_err;

  int   n_checks = 0;
  int   n_fail   = 0;
  sb_t  sb[$];
  logic [7:0] rcon_tab [10];
  vec_t vecs [NVEC];

  aes_round_ctrl dut (
    .clk          (clk),
    .rst_         (rst_),
    .start        (start),
    .start_ack    (start_ack),
    .ready        (ready),
    .load_state   (load_state),
    .load_key     (load_key),
    .round_en     (round_en),
    .round        (round),
    .rcon         (rcon),
    .last_round   (last_round),
    .cipher_valid (cipher_valid),
    .out_ack      (out_ack),
    .busy_err     (busy_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic out_t cur();
    out_t o;
    o.ready      = ready;
    o.start_ack  = start_ack;
    o.load_state = load_state;
    o.load_key   = load_key;
    o.round_en   = round_en;
    o.round      = round;
    o.last       = last_round;
    o.valid      = cipher_valid;
    o.busy_err   = busy_err;
    return o;
  endfunction

  task automatic push_run();
    for (int k = 1; k <= 10; k++) begin
      sb_t e;
      e.round = 4'(k);
      e.rcon  = rcon_tab[k-1];
      e.last  = (k == 10);
      sb.push_back(e);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the ack cycle.
  task automatic do_start(input string tag);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    start = 1'b1;
    push_run();
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_ack"}, 32'(start_ack), 32'd1);
    check({tag, "_load"}, 32'({load_state, load_key}), 32'd3);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int steps);
    steps = 0;
    while (!cipher_valid && steps < budget) begin
      @(negedge clk);
      steps++;
    end
    check({tag, "_valid_seen"}, 32'(cipher_valid), 32'd1);
  endtask

  task automatic ack_out(input string tag);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    check({tag, "_ready_after_ack"}, 32'(ready), 32'd1);
  endtask

  always @(negedge clk) begin
    if (round_en) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_underflow: got round %0d with nothing expected", round);
      end else begin
        sb_t e;
        e = sb.pop_front();
        check($sformatf("sb_round%0d", e.round), 32'({round, rcon, last_round}), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   steps;
    out_t e;
    out_t idle_exp;

    rcon_tab[0] = 8'h01; rcon_tab[1] = 8'h02; rcon_tab[2] = 8'h04; rcon_tab[3] = 8'h08;
    rcon_tab[4] = 8'h10; rcon_tab[5] = 8'h20; rcon_tab[6] = 8'h40; rcon_tab[7] = 8'h80;
    rcon_tab[8] = 8'h1B; rcon_tab[9] = 8'h36;

    idle_exp       = '0;
    idle_exp.ready = 1'b1;

    // One full run: start, load, ten rounds, 21 cycles of held result, ack.
    for (int i = 0; i < NVEC; i++) begin
      e = '0;
      if (i == 0 || i == 33) begin
        e.ready = 1'b1;
      end else if (i == 1) begin
        e.start_ack  = 1'b1;
        e.load_state = 1'b1;
        e.load_key   = 1'b1;
      end else if (i <= 11) begin
        e.round_en = 1'b1;
        e.round    = 4'(i - 1);
        e.last     = (i == 11);
      end else begin
        e.valid = 1'b1;
      end
      vecs[i].start   = (i == 0);
      vecs[i].out_ack = (i == 32);
      vecs[i].exp     = e;
    end

    rst_    = 1'b0;
    start   = 1'b0;
    out_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(cur()), 32'(idle_exp));
    check("reset_rcon", 32'(rcon), 32'h01);
    rst_ = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("vec%0d", i), 32'(cur()), 32'(vecs[i].exp));
      start   = vecs[i].start;
      out_ack = vecs[i].out_ack;
      if (vecs[i].start) push_run();
      @(negedge clk);
    end
    start   = 1'b0;
    out_ack = 1'b0;

    // Start arriving mid-run at round 5.
    do_start("t4");
    repeat (5) @(negedge clk);
    check("t4_round5", 32'(round), 32'd5);
    start = 1'b1;
`ifdef AES_CMD_QUEUE_EN
    push_run();
`endif
    @(negedge clk);
    start = 1'b0;
`ifdef AES_CMD_QUEUE_EN
    check("t4_busy_err_queued", 32'(busy_err), 32'd0);
`else
    check("t4_busy_err_pulse", 32'(busy_err), 32'd1);
`endif
    @(negedge clk);
    check("t4_busy_err_clear", 32'(busy_err), 32'd0);
    wait_valid("t4", 40, steps);
    check("t4_latency", 32'(steps), 32'd4);
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
`ifdef AES_CMD_QUEUE_EN
    check("t4_queued_start_ack", 32'(start_ack), 32'd1);
    check("t4_queued_not_ready", 32'(ready), 32'd0);
    wait_valid("t4q", 40, steps);
    check("t4q_latency", 32'(steps), 32'd11);
    ack_out("t4q");
`else
    check("t4_ready_after_ack", 32'(ready), 32'd1);
    check("t4_no_start_ack", 32'(start_ack), 32'd0);
    @(negedge clk);
    check("t4_still_idle", 32'(cur()), 32'(idle_exp));
`endif

    // Reset asserted at round 6 abandons the run.
    do_start("t5");
    repeat (6) @(negedge clk);
    check("t5_round6", 32'(round), 32'd6);
    rst_ = 1'b0;
    #1;
    check("t5_rst_ready", 32'(ready), 32'd1);
    check("t5_rst_round", 32'(round), 32'd0);
    check("t5_rst_rcon", 32'(rcon), 32'h01);
    check("t5_rst_round_en", 32'(round_en), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_ = 1'b1;
    @(negedge clk);
    do_start("t5b");
    wait_valid("t5b", 40, steps);
    check("t5b_latency", 32'(steps), 32'd11);
    check("t5b_sb_drained", 32'(sb.size()), 32'd0);

    // start together with out_ack in S_DONE is not accepted.
    start   = 1'b1;
    out_ack = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    out_ack = 1'b0;
    check("t6_ready", 32'(ready), 32'd1);
    check("t6_no_start_ack", 32'(start_ack), 32'd0);
    check("t6_valid_dropped", 32'(cipher_valid), 32'd0);
    do_start("t6b");
    wait_valid("t6b", 40, steps);
    check("t6b_latency", 32'(steps), 32'd11);
    ack_out("t6b");

    @(negedge clk);
    check("final_sb_drained", 32'(sb.size()), 32'd0);
    check("final_idle", 32'(cur()), 32'(idle_exp));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
